// File: rtl/iiitb_sd_pkg.sv
// rtl/iiitb_sd_pkg.sv - shared types and helpers for the sequence-detector stream controller
package iiitb_sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_WAIT,
      ST_SHIFT,
      ST_DRAIN
   } sd_state_e;

   // Moore detector: output reflects the bit seen one clock earlier
   localparam int DET_LAT_DEF = 1;

   // bit-index width for a word of word_w bits, never below one bit
   function automatic int sd_clog2(input int word_w);
      return (word_w <= 2) ? 1 : $clog2(word_w);
   endfunction

endpackage

// File: rtl/iiitb_sd_ser.sv
// rtl/iiitb_sd_ser.sv - loadable MSB-first shift register with bit-index counter
module iiitb_sd_ser
   import iiitb_sd_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic                          load_i,
   input  logic                          shift_i,
   input  logic [WORD_W-1:0]             data_i,
   output logic                          bit_o,
   output logic [sd_clog2(WORD_W)-1:0]   idx_o,
   output logic                          last_o
);

   localparam int IDX_W = sd_clog2(WORD_W);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   // load wins over shift; shifting in zeros leaves the register empty after the last bit
   always_comb begin
      sr_d  = sr_q;
      idx_d = idx_q;
      if (load_i) begin
         sr_d  = data_i;
         idx_d = '0;
      end else if (shift_i) begin
         sr_d  = {sr_q[WORD_W-2:0], 1'b0};
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // shift register and index state
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sr_q  <= '0;
         idx_q <= '0;
      end else begin
         sr_q  <= sr_d;
         idx_q <= idx_d;
      end
   end

   assign bit_o  = sr_q[WORD_W-1];
   assign idx_o  = idx_q;
   assign last_o = (idx_q == IDX_W'(WORD_W-1));

endmodule

// File: rtl/iiitb_sd_ctrl.sv
// rtl/iiitb_sd_ctrl.sv - word-to-bit stream controller and hit counter for a sequence detector
module iiitb_sd_ctrl
   import iiitb_sd_pkg::*;
#(
   parameter int WORD_W  = 8,
   parameter int CNT_W   = 16,
   parameter int DET_LAT = DET_LAT_DEF
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          in_valid,
   input  logic [WORD_W-1:0]             in_data,
   output logic                          in_ready,
   output logic                          seq_out,
   output logic                          det_reset,
   input  logic                          det_in,
   output logic                          busy,
   output logic                          hit_pulse,
   output logic [sd_clog2(WORD_W)-1:0]   hit_pos,
   output logic [CNT_W-1:0]              hit_count,
   output logic                          overflow
);

   localparam int IDX_W = sd_clog2(WORD_W);
   localparam int DRN_W = (DET_LAT < 2) ? 1 : $clog2(DET_LAT);

   sd_state_e        state_q, state_d;
   logic             det_reset_q, det_reset_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [IDX_W-1:0] idx_dly_q [DET_LAT];
   logic             hit_pulse_q, hit_pulse_d;
   logic [IDX_W-1:0] hit_pos_q, hit_pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             accept, hit;
   logic             ser_bit, ser_last;
   logic [IDX_W-1:0] ser_idx;

   iiitb_sd_ser #(.WORD_W(WORD_W)) u_ser (
      .clock_i (clock),
      .reset_i (reset),
      .load_i  (accept),
      .shift_i (state_q == ST_SHIFT),
      .data_i  (in_data),
      .bit_o   (ser_bit),
      .idx_o   (ser_idx),
      .last_o  (ser_last)
   );

   // next state, drain timer and input-ready decode
   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      in_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            in_ready = enable;
            if (in_valid && enable) state_d = ST_SHIFT;
            else if (!enable)       state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            drain_d  = '0;
            in_ready = enable && ser_last;
            // a handshake on the last bit keeps the stream continuous
            if (ser_last && !(in_valid && enable)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            drain_d = drain_q + DRN_W'(1);
            if (drain_q == DRN_W'(DET_LAT-1)) begin
               drain_d = '0;
               state_d = enable ? ST_FLUSH : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      accept      = in_valid && in_ready;
      det_reset_d = (state_d == ST_FLUSH);
   end

   // FSM state register; the detector is held in reset alongside the controller
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         drain_q     <= '0;
         det_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         det_reset_q <= det_reset_d;
      end
   end

   // delay the presented bit index so it lines up with the detector response
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DET_LAT; i++) idx_dly_q[i] <= '0;
      end else begin
         idx_dly_q[0] <= ser_idx;
         for (int i = 1; i < DET_LAT; i++) idx_dly_q[i] <= idx_dly_q[i-1];
      end
   end

   // hit qualification with a saturating counter and sticky overflow
   always_comb begin
      hit         = det_in && ((state_q == ST_SHIFT) || (state_q == ST_DRAIN));
      hit_pulse_d = hit;
      hit_pos_d   = hit_pos_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      if (hit) begin
         hit_pos_d = idx_dly_q[DET_LAT-1];
         if (&cnt_q) ovf_d = 1'b1;
         else        cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // hit reporting registers
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_pulse_q <= 1'b0;
         hit_pos_q   <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         hit_pulse_q <= hit_pulse_d;
         hit_pos_q   <= hit_pos_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign seq_out   = ser_bit;
   assign det_reset = det_reset_q;
   assign busy      = (state_q != ST_IDLE);
   assign hit_pulse = hit_pulse_q;
   assign hit_pos   = hit_pos_q;
   assign hit_count = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_iiitb_sd_ctrl.sv
// tb/tb_iiitb_sd_ctrl.sv - directed self-checking bench for iiitb_sd_ctrl
module tb_iiitb_sd_ctrl;

   logic        clock, reset, enable, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, seq_out, det_reset, det_in, busy, hit_pulse, overflow;
   logic [2:0]  hit_pos;
   logic [15:0] hit_count;
   logic        s_in_ready, s_seq_out, s_det_reset, s_det_in, s_busy, s_hit_pulse, s_overflow;
   logic [2:0]  s_hit_pos;
   logic [3:0]  s_hit_count;
   logic [2:0]  det_st, s_det_st;

   int          checks, failures;
   int          sat_hits, ovf_first;
   logic [63:0] seq_log, dr_log, busy_log, rdy_log, pulse_log;

   iiitb_sd_ctrl #(.WORD_W(8), .CNT_W(16), .DET_LAT(1)) u_dut (
      .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .seq_out(seq_out), .det_reset(det_reset), .det_in(det_in),
      .busy(busy), .hit_pulse(hit_pulse), .hit_pos(hit_pos), .hit_count(hit_count),
      .overflow(overflow)
   );

   iiitb_sd_ctrl #(.WORD_W(8), .CNT_W(4), .DET_LAT(1)) u_sat (
      .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
      .in_ready(s_in_ready), .seq_out(s_seq_out), .det_reset(s_det_reset), .det_in(s_det_in),
      .busy(s_busy), .hit_pulse(s_hit_pulse), .hit_pos(s_hit_pos), .hit_count(s_hit_count),
      .overflow(s_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Moore 1011 detector with overlap, synchronous active-high reset
   function automatic logic [2:0] det_next(input logic [2:0] st, input logic b);
      case (st)
         3'd0:    return b ? 3'd1 : 3'd0;
         3'd1:    return b ? 3'd1 : 3'd2;
         3'd2:    return b ? 3'd3 : 3'd0;
         3'd3:    return b ? 3'd4 : 3'd2;
         default: return b ? 3'd1 : 3'd2;
      endcase
   endfunction

   initial begin
      det_st   = 3'd0;
      s_det_st = 3'd0;
   end
   always @(posedge clock) det_st   <= det_reset   ? 3'd0 : det_next(det_st, seq_out);
   always @(posedge clock) s_det_st <= s_det_reset ? 3'd0 : det_next(s_det_st, s_seq_out);
   assign det_in   = (det_st == 3'd4);
   assign s_det_in = (s_det_st == 3'd4);

   task automatic clear_logs();
      seq_log = '0; dr_log = '0; busy_log = '0; rdy_log = '0; pulse_log = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      seq_log   = {seq_log[62:0], seq_out};
      dr_log    = {dr_log[62:0], det_reset};
      busy_log  = {busy_log[62:0], busy};
      rdy_log   = {rdy_log[62:0], in_ready};
      pulse_log = {pulse_log[62:0], hit_pulse};
      if (s_hit_pulse) sat_hits++;
      if (s_overflow && ovf_first == 0) ovf_first = sat_hits;
   endtask

   task automatic apply_reset();
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic push_word(input logic [7:0] w);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 64 && !done; i++) begin
         done = in_ready;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL push_timeout word=%h was not accepted within 64 cycles", w);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick();
      tick();
      checks += 8;
      if (seq_out !== 1'b0)    begin failures++; $display("FAIL rst_seq_out got=%b exp=0", seq_out); end
      if (in_ready !== 1'b0)   begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (hit_pulse !== 1'b0)  begin failures++; $display("FAIL rst_hit_pulse got=%b exp=0", hit_pulse); end
      if (hit_pos !== 3'd0)    begin failures++; $display("FAIL rst_hit_pos got=%0d exp=0", hit_pos); end
      if (hit_count !== 16'd0) begin failures++; $display("FAIL rst_hit_count got=%0d exp=0", hit_count); end
      if (overflow !== 1'b0)   begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
      if (det_reset !== 1'b1)  begin failures++; $display("FAIL rst_det_reset got=%b exp=1", det_reset); end
   endtask

   task automatic test_single_word();
      apply_reset();
      enable = 1'b1;
      push_word(8'hB0);
      enable = 1'b0;
      repeat (9) tick();
      checks += 7;
      if (seq_log !== 64'h2C0)   begin failures++; $display("FAIL t1_seq got=%h exp=2c0", seq_log); end
      if (dr_log !== 64'h800)    begin failures++; $display("FAIL t1_det_reset got=%h exp=800", dr_log); end
      if (busy_log !== 64'hFFE)  begin failures++; $display("FAIL t1_busy got=%h exp=ffe", busy_log); end
      if (rdy_log !== 64'h400)   begin failures++; $display("FAIL t1_ready got=%h exp=400", rdy_log); end
      if (pulse_log !== 64'h010) begin failures++; $display("FAIL t1_pulse got=%h exp=010", pulse_log); end
      if (hit_pos !== 3'd3)      begin failures++; $display("FAIL t1_hit_pos got=%0d exp=3", hit_pos); end
      if (hit_count !== 16'd1)   begin failures++; $display("FAIL t1_hit_count got=%0d exp=1", hit_count); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      enable = 1'b1;
      push_word(8'h02);
      push_word(8'hC0);
      enable = 1'b0;
      repeat (9) tick();
      checks += 7;
      if (seq_log !== 64'h00B00)   begin failures++; $display("FAIL t2_seq got=%h exp=00b00", seq_log); end
      if (dr_log !== 64'h80000)    begin failures++; $display("FAIL t2_det_reset got=%h exp=80000", dr_log); end
      if (busy_log !== 64'hFFFFE)  begin failures++; $display("FAIL t2_busy got=%h exp=ffffe", busy_log); end
      if (rdy_log !== 64'h40400)   begin failures++; $display("FAIL t2_ready got=%h exp=40400", rdy_log); end
      if (pulse_log !== 64'h00040) begin failures++; $display("FAIL t2_pulse got=%h exp=00040", pulse_log); end
      if (hit_pos !== 3'd1)        begin failures++; $display("FAIL t2_hit_pos got=%0d exp=1", hit_pos); end
      if (hit_count !== 16'd1)     begin failures++; $display("FAIL t2_hit_count got=%0d exp=1", hit_count); end
   endtask

   task automatic test_gap();
      apply_reset();
      enable = 1'b1;
      push_word(8'h02);
      repeat (8) tick();
      push_word(8'hC0);
      enable = 1'b0;
      repeat (9) tick();
      checks += 6;
      if (seq_log !== 64'h4300)     begin failures++; $display("FAIL t3_seq got=%h exp=4300", seq_log); end
      if (dr_log !== 64'h400800)    begin failures++; $display("FAIL t3_det_reset got=%h exp=400800", dr_log); end
      if (busy_log !== 64'h7FFFFE)  begin failures++; $display("FAIL t3_busy got=%h exp=7ffffe", busy_log); end
      if (rdy_log !== 64'h202400)   begin failures++; $display("FAIL t3_ready got=%h exp=202400", rdy_log); end
      if (pulse_log !== 64'h0)      begin failures++; $display("FAIL t3_pulse got=%h exp=0", pulse_log); end
      if (hit_count !== 16'd0)      begin failures++; $display("FAIL t3_hit_count got=%0d exp=0", hit_count); end
   endtask

   task automatic test_saturation();
      apply_reset();
      sat_hits  = 0;
      ovf_first = 0;
      enable = 1'b1;
      for (int i = 0; i < 17; i++) push_word(8'hB0);
      enable = 1'b0;
      repeat (12) tick();
      checks += 5;
      if (s_hit_count !== 4'd15) begin failures++; $display("FAIL t4_sat_count got=%0d exp=15", s_hit_count); end
      if (s_overflow !== 1'b1)   begin failures++; $display("FAIL t4_sat_overflow got=%b exp=1", s_overflow); end
      if (ovf_first !== 16)      begin failures++; $display("FAIL t4_ovf_at_hit got=%0d exp=16", ovf_first); end
      if (hit_count !== 16'd17)  begin failures++; $display("FAIL t4_wide_count got=%0d exp=17", hit_count); end
      if (overflow !== 1'b0)     begin failures++; $display("FAIL t4_wide_overflow got=%b exp=0", overflow); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks += 2;
      if (s_hit_count !== 4'd0) begin failures++; $display("FAIL t4_clear_count got=%0d exp=0", s_hit_count); end
      if (s_overflow !== 1'b0)  begin failures++; $display("FAIL t4_clear_overflow got=%b exp=0", s_overflow); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      enable = 1'b1;
      push_word(8'hB0);
      repeat (3) tick();
      reset  = 1'b1;
      enable = 1'b0;
      tick();
      checks += 8;
      if (seq_out !== 1'b0)    begin failures++; $display("FAIL t5_seq_out got=%b exp=0", seq_out); end
      if (in_ready !== 1'b0)   begin failures++; $display("FAIL t5_in_ready got=%b exp=0", in_ready); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL t5_busy got=%b exp=0", busy); end
      if (hit_pulse !== 1'b0)  begin failures++; $display("FAIL t5_hit_pulse got=%b exp=0", hit_pulse); end
      if (hit_pos !== 3'd0)    begin failures++; $display("FAIL t5_hit_pos got=%0d exp=0", hit_pos); end
      if (hit_count !== 16'd0) begin failures++; $display("FAIL t5_hit_count got=%0d exp=0", hit_count); end
      if (overflow !== 1'b0)   begin failures++; $display("FAIL t5_overflow got=%b exp=0", overflow); end
      if (det_reset !== 1'b1)  begin failures++; $display("FAIL t5_det_reset got=%b exp=1", det_reset); end
      reset = 1'b0;
      clear_logs();
      repeat (4) tick();
      checks += 4;
      if (busy_log !== 64'h0)  begin failures++; $display("FAIL t5_idle_busy got=%h exp=0", busy_log); end
      if (dr_log !== 64'h0)    begin failures++; $display("FAIL t5_idle_det_reset got=%h exp=0", dr_log); end
      if (pulse_log !== 64'h0) begin failures++; $display("FAIL t5_idle_pulse got=%h exp=0", pulse_log); end
      if (hit_count !== 16'd0) begin failures++; $display("FAIL t5_idle_count got=%0d exp=0", hit_count); end
      enable = 1'b1;
      tick();
      checks += 2;
      if (det_reset !== 1'b1) begin failures++; $display("FAIL t5_rearm_det_reset got=%b exp=1", det_reset); end
      if (busy !== 1'b1)      begin failures++; $display("FAIL t5_rearm_busy got=%b exp=1", busy); end
   endtask

   task automatic test_enable_drop();
      apply_reset();
      enable = 1'b1;
      push_word(8'hB0);
      tick();
      enable = 1'b0;
      clear_logs();
      repeat (8) tick();
      checks += 6;
      if (seq_log !== 64'hC0)   begin failures++; $display("FAIL t6_seq got=%h exp=c0", seq_log); end
      if (busy_log !== 64'hFE)  begin failures++; $display("FAIL t6_busy got=%h exp=fe", busy_log); end
      if (rdy_log !== 64'h0)    begin failures++; $display("FAIL t6_ready got=%h exp=0", rdy_log); end
      if (dr_log !== 64'h0)     begin failures++; $display("FAIL t6_det_reset got=%h exp=0", dr_log); end
      if (pulse_log !== 64'h10) begin failures++; $display("FAIL t6_pulse got=%h exp=10", pulse_log); end
      if (hit_count !== 16'd1)  begin failures++; $display("FAIL t6_hit_count got=%0d exp=1", hit_count); end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      sat_hits  = 0;
      ovf_first = 0;
      clear_logs();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_gap();
      test_saturation();
      test_mid_reset();
      test_enable_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
